control_sequencer: RTL

//  Hardwired multi-cycle control unit that drives the datapath's bus-out/reg-in strobes.
//  It replaces hand-sequenced T0..T5 stimulus with an FSM that covers:

---
 rtl/control_sequencer_pkg.sv | 89 ++++++++
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer_reg_select_decoder.sv | 19 +
 rtl/control_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the hardwired control sequencer: FSM states,
// opcode map, ALU operation codes and default IR field positions.
package cpu_ctrl_pkg;

  localparam int DEF_NUM_REGS    = 16;
  localparam int DEF_REG_FIELD_W = 4;
  localparam int DEF_OPCODE_W    = 5;
  localparam int DEF_IR_W        = 32;
  localparam int DEF_ALU_OP_W    = 4;
  localparam int DEF_MEM_TIMEOUT = 15;

  // IR field positions for the default 32-bit format
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
  } state_t;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHRA = 5'b01000;
  localparam opcode_t OP_SHL  = 5'b01001;
  localparam opcode_t OP_ROR  = 5'b01010;
  localparam opcode_t OP_ROL  = 5'b01011;
  localparam opcode_t OP_MUL  = 5'b01110;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_AND  = 4'd2;
  localparam alu_op_t ALU_OR   = 4'd3;
  localparam alu_op_t ALU_SHR  = 4'd4;
  localparam alu_op_t ALU_SHRA = 4'd5;
  localparam alu_op_t ALU_SHL  = 4'd6;
  localparam alu_op_t ALU_ROR  = 4'd7;
  localparam alu_op_t ALU_ROL  = 4'd8;
  localparam alu_op_t ALU_MUL  = 4'd9;
  localparam alu_op_t ALU_DIV  = 4'd10;
  // PC increment during fetch T0
  localparam alu_op_t ALU_INC  = 4'd11;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_cls_t;

  function automatic instr_cls_t classify(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU;
      OP_MUL, OP_DIV:                  return CLS_MULDIV;
      OP_NOP:                          return CLS_NOP;
      OP_HALT:                         return CLS_HALT;
      default:                         return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic alu_op_t alu_op_of(input opcode_t op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHRA: return ALU_SHRA;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath (slave):
// run/stall/memory handshake and IR in, strobes, selects and status out.
interface control_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int IR_W     = 32,
  parameter int ALU_OP_W = 4
);
  logic                Run;
  logic                Stall;
  logic                mem_ready;
  logic [IR_W-1:0]     IR;
  logic                PCout, MARin, IncPC, PCin;
  logic                Read, MDRin, MDRout;
  logic                IRin, Yin, Zin;
  logic                ZLOout, ZHIout, HIin, LOin;
  logic [NUM_REGS-1:0] Rout_sel;
  logic [NUM_REGS-1:0] Rin_sel;
  logic [ALU_OP_W-1:0] alu_op;
  logic                Done, Fault, Halted;

  modport master (
    input  Run, Stall, mem_ready, IR,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
           ZLOout, ZHIout, HIin, LOin, Rout_sel, Rin_sel, alu_op,
           Done, Fault, Halted
  );

  modport slave (
    output Run, Stall, mem_ready, IR,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin,
           ZLOout, ZHIout, HIin, LOin, Rout_sel, Rin_sel, alu_op,
           Done, Fault, Halted
  );
endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// Register index to one-hot select; an out-of-range index with enable set
// yields an all-zero select and raises oor.
module reg_select_decoder #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel,
  output logic                oor
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
    assign sel[i] = en && (int'(idx) == i);
  end

  assign oor = en && (int'(idx) >= NUM_REGS);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch with memory wait, ALU and MUL/DIV
// execute, NOP, HALT and fault handling, decoded from registered state and IR.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int REG_FIELD_W = 4,
  parameter int OPCODE_W    = 5,
  parameter int IR_W        = 32,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

  localparam int F_OP_LSB = IR_W - OPCODE_W;
  localparam int F_RA_LSB = F_OP_LSB - REG_FIELD_W;
  localparam int F_RB_LSB = F_RA_LSB - REG_FIELD_W;
  localparam int F_RC_LSB = F_RB_LSB - REG_FIELD_W;
  localparam int CNT_W    = $clog2(MEM_TIMEOUT + 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt;
  logic [OPCODE_W-1:0]    op;
  logic [REG_FIELD_W-1:0] ra, rb, rc;
  instr_cls_t             cls;
  logic                   is_md;
  logic                   fields_ok;
  alu_op_t                alu_code;
  logic                   rout_en, rin_en;
  logic [REG_FIELD_W-1:0] rout_idx, rin_idx;
  logic                   rout_oor, rin_oor;
  logic                   unused_ir;

  assign op        = bus.IR[IR_W-1 -: OPCODE_W];
  assign ra        = bus.IR[F_OP_LSB-1 -: REG_FIELD_W];
  assign rb        = bus.IR[F_RA_LSB-1 -: REG_FIELD_W];
  assign rc        = bus.IR[F_RB_LSB-1 -: REG_FIELD_W];
  assign unused_ir = ^bus.IR[F_RC_LSB-1:0];

  assign cls   = classify(opcode_t'(op));
  assign is_md = (cls == CLS_MULDIV);

  function automatic logic in_range(input logic [REG_FIELD_W-1:0] r);
    return int'(r) < NUM_REGS;
  endfunction

  // Only the fields an instruction actually uses are range-checked.
  assign fields_ok = (cls == CLS_ALU)    ? (in_range(ra) && in_range(rb) && in_range(rc)) :
                     (cls == CLS_MULDIV) ? (in_range(ra) && in_range(rb)) : 1'b1;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.ZLOout   = 1'b0;
    bus.ZHIout   = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Done     = 1'b0;
    alu_code     = ALU_ADD;
    rout_en      = 1'b0;
    rout_idx     = '0;
    rin_en       = 1'b0;
    rin_idx      = '0;

    unique case (state)
      S_IDLE: if (bus.Run && !bus.Stall) state_nxt = S_T0;
      S_T0: begin
        bus.PCout    = 1'b1;
        bus.MARin    = 1'b1;
        bus.IncPC    = 1'b1;
        bus.Zin      = 1'b1;
        alu_code     = ALU_INC;
        wait_cnt_nxt = '0;
        state_nxt    = S_T1;
      end
      S_T1: begin
        // Read/MDRin stay up for the whole wait; PC is written back only once.
        bus.ZLOout = 1'b1;
        bus.PCin   = (wait_cnt == '0);
        bus.Read   = 1'b1;
        bus.MDRin  = 1'b1;
        if (bus.mem_ready) begin
          state_nxt = S_T2;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (wait_cnt_nxt == CNT_W'(MEM_TIMEOUT)) state_nxt = S_FAULT;
        end
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_nxt  = S_T3;
      end
      S_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: begin
            if (fields_ok) begin
              rout_en   = 1'b1;
              rout_idx  = is_md ? ra : rb;
              bus.Yin   = 1'b1;
              state_nxt = S_T4;
            end else begin
              state_nxt = S_FAULT;
            end
          end
          CLS_NOP: begin
            bus.Done  = 1'b1;
            state_nxt = S_IDLE;
          end
          CLS_HALT: state_nxt = S_HALT;
          default:  state_nxt = S_FAULT;
        endcase
      end
      S_T4: begin
        rout_en   = 1'b1;
        rout_idx  = is_md ? rb : rc;
        bus.Zin   = 1'b1;
        alu_code  = alu_op_of(opcode_t'(op));
        state_nxt = S_T5;
      end
      S_T5: begin
        bus.ZLOout = 1'b1;
        if (is_md) begin
          bus.LOin  = 1'b1;
          state_nxt = S_T6;
        end else begin
          rin_en    = 1'b1;
          rin_idx   = ra;
          bus.Done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_T6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
        bus.Done   = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_HALT, S_FAULT: state_nxt = state;
      default:         state_nxt = S_IDLE;
    endcase
  end

  assign bus.alu_op = ALU_OP_W'(alu_code);
  assign bus.Fault  = (state == S_FAULT);
  assign bus.Halted = (state == S_HALT);

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(REG_FIELD_W)) u_rout (
    .idx (rout_idx),
    .en  (rout_en),
    .sel (bus.Rout_sel),
    .oor (rout_oor)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(REG_FIELD_W)) u_rin (
    .idx (rin_idx),
    .en  (rin_en),
    .sel (bus.Rin_sel),
    .oor (rin_oor)
  );

  // The T3 range check must keep every later select in range.
  assert property (@(posedge Clock) disable iff (Clear) !(rout_oor || rin_oor));

endmodule
